// File: rtl/pwm_measure_unit.sv
// pwm_measure_unit: measures the high-time of an asynchronous PWM input in
// units of CLK_DIV clock cycles and holds the most recent completed pulse
// width on `distance`. An optional idle timeout clears the result when no
// pulse has completed for TIMEOUT_CYCLES cycles.
module pwm_measure_unit #(
  parameter int CLK_DIV        = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [15:0] distance
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Measurement synchronizer (cleared by reset) and edge history.
  logic s1, s2, s3;
  // Free-running copy of the input, not cleared by reset, so we can tell
  // whether the pin was already high while reset was asserted.
  logic q1, q2;
  logic ign;

  logic          rise, fall, accept;
  logic          armed;
  logic [DW-1:0] div_cnt;
  logic [15:0]   cnt;
  logic          timeout_fire;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Unreset synchronizer used only to qualify the first rise after reset.
  always_ff @(posedge clk) begin
    q1 <= pwm_in;
    q2 <= q1;
  end

  assign rise   = s2 & ~s3;
  assign fall   = ~s2 & s3;
  assign accept = fall & armed;

  // A pulse that was high during reset looks like a fresh rise once the
  // cleared synchronizer catches up; ignore it until the pin is seen low.
  always_ff @(posedge clk) begin
    if (reset)    ign <= q2;
    else if (!q2) ign <= 1'b0;
  end

  // Only a rise we actually saw arms the next fall for reporting.
  always_ff @(posedge clk) begin
    if (reset)              armed <= 1'b0;
    else if (fall)          armed <= 1'b0;
    else if (rise && !ign)  armed <= 1'b1;
  end

  // Prescaled high-time counter; cleared whenever the synced input is low,
  // saturating at 0xFFFF for very long pulses.
  always_ff @(posedge clk) begin
    if (reset || !s2) begin
      div_cnt <= '0;
      cnt     <= '0;
    end else if (div_cnt == DW'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
      logic [IW-1:0] idle;

      // Cycles since the last accepted fall; parks at TIMEOUT_CYCLES.
      always_ff @(posedge clk) begin
        if (reset)                             idle <= '0;
        else if (accept)                       idle <= '0;
        else if (idle != IW'(TIMEOUT_CYCLES))  idle <= idle + IW'(1);
      end

      // Fires on the single edge at which the idle count reaches the limit.
      assign timeout_fire = (idle == IW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign timeout_fire = 1'b0;
    end
  endgenerate

  // Result register: a completed pulse takes priority over the timeout.
  always_ff @(posedge clk) begin
    if (reset)             distance <= 16'h0000;
    else if (accept)       distance <= cnt;
    else if (timeout_fire) distance <= 16'h0000;
  end

endmodule

// File: tb/tb_pwm_measure_unit.sv
// Bench for pwm_measure_unit: a table of pulses on the default instance with a
// scoreboard of expected distance updates, plus hand-written sequences for
// latency, reset mid-pulse, prescaling and the idle timeout.
module tb_pwm_measure_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_in, pwm_b;
  logic [15:0] distance, dist_b;

  always #5 clk = ~clk;

  pwm_measure_unit dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .distance(distance)
  );

  pwm_measure_unit #(.CLK_DIV(4), .TIMEOUT_CYCLES(100)) dut4 (
    .clk(clk), .reset(reset), .pwm_in(pwm_b), .distance(dist_b)
  );

  typedef struct {
    int          hi;
    int          lo;
    logic [15:0] exp;
  } vec_t;

  int          npass = 0;
  int          ntot  = 0;
  logic [15:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [15:0] mon_last;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every change of distance must match the next queued value.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && distance !== mon_last) begin
        if (exp_q.size() == 0) begin
          ntot++;
          $display("FAIL sb_unexpected: got %0h want no update", distance);
        end else begin
          chk("sb_update", distance, exp_q.pop_front());
        end
        mon_last = distance;
      end
    end
  end

  initial begin
    vecs[0] = '{5,     40, 16'd5};
    vecs[1] = '{500,   40, 16'd500};
    vecs[2] = '{1,     1,  16'd1};
    vecs[3] = '{2,     1,  16'd2};
    vecs[4] = '{1,     40, 16'd1};
    vecs[5] = '{70000, 40, 16'hFFFF};
    vecs[6] = '{33,    40, 16'd33};

    reset  = 1'b1;
    pwm_in = 1'b0;
    pwm_b  = 1'b0;
    repeat (10) begin
      tick();
      chk("reset_dist", distance, 16'h0000);
    end
    mon_last = 16'h0000;
    mon_en   = 1'b1;

    // Rise in the same cycle reset deasserts: measured in full.
    reset  = 1'b0;
    pwm_in = 1'b1;
    exp_q.push_back(16'd20);
    repeat (20) tick();
    pwm_in = 1'b0;
    tick();                          // edge k samples low
    chk("lat_k", distance, 16'd0);
    tick();
    chk("lat_k1", distance, 16'd0);
    tick();
    chk("lat_k2", distance, 16'd20);
    repeat (37) tick();
    chk("hold_20", distance, 16'd20);

    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].exp);
      pwm_in = 1'b1;
      repeat (vecs[i].hi) tick();
      pwm_in = 1'b0;
      repeat (vecs[i].lo) tick();
      chk("vec_end", distance, vecs[i].lo > 2 ? vecs[i].exp : distance);
    end

    // Reset mid-pulse: result cleared, remainder of that pulse not reported.
    exp_q.push_back(16'd0);
    pwm_in = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    chk("rst_clear", distance, 16'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    pwm_in = 1'b0;
    repeat (40) tick();
    chk("rst_no_report", distance, 16'd0);
    exp_q.push_back(16'd10);
    pwm_in = 1'b1;
    repeat (10) tick();
    pwm_in = 1'b0;
    repeat (40) tick();
    chk("after_rst", distance, 16'd10);

    // Prescaled instance: 19 cycles / 4 -> 4, then the idle timeout.
    pwm_b = 1'b1;
    repeat (19) tick();
    pwm_b = 1'b0;
    tick();
    tick();
    chk("div4_pre", dist_b, 16'd0);
    tick();                          // accepted fall edge
    chk("div4_19", dist_b, 16'd4);
    repeat (99) tick();
    chk("tmo_before", dist_b, 16'd4);
    tick();
    chk("tmo_fire", dist_b, 16'd0);
    repeat (20) tick();
    chk("tmo_hold", dist_b, 16'd0);

    pwm_b = 1'b1;
    repeat (8) tick();
    pwm_b = 1'b0;
    repeat (3) tick();
    chk("div4_8", dist_b, 16'd2);
    repeat (10) tick();

    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    chk("dflt_final", distance, 16'd10);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
